// File: rtl/i2c_slave_target.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2c_slave_target: oversampled I2C target, fixed-address ACK, write sink   |
// | and read source. Define I2C_SLAVE_GENCALL_EN to also ACK general call.    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module i2c_slave_target #(
    parameter int                  ADDR_LEN    = 7,
    parameter int                  DATA_LEN    = 8,
    parameter logic [ADDR_LEN-1:0] SLAVE_ADDR  = 7'h2A,
    parameter int                  SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                scl,
    inout  wire                 sda,
    input  logic [DATA_LEN-1:0] tx_data,
    output logic                tx_req,
    output logic [DATA_LEN-1:0] rx_data,
    output logic                rx_valid,
    output logic                addr_hit,
    output logic                rw_dir,
    output logic                busy
);

    localparam int SHIFT_W = (ADDR_LEN + 1 > DATA_LEN) ? ADDR_LEN + 1 : DATA_LEN;
    localparam int CNT_W   = $clog2(SHIFT_W + 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_LEN);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_LEN - 1);
    localparam logic [CNT_W-1:0] DATA_DONE = CNT_W'(DATA_LEN);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SHIFT_W-1:0]     shift_q, shift_d;
    logic                   sda_oe_q, sda_oe_d;
    logic [DATA_LEN-1:0]    rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   tx_req_q, tx_req_d;
    logic                   addr_hit_q, addr_hit_d;
    logic                   rw_dir_q, rw_dir_d;
    logic                   busy_q, busy_d;

    logic scl_s, sda_s, scl_rise, scl_fall, start_cond, stop_cond, gencall, addr_ok;

    assign scl_s    = scl_sync_q[SYNC_STAGES-1];
    assign sda_s    = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_prev_q;
    assign scl_fall = ~scl_s & scl_prev_q;
    // scl must be stable high across both samples, so a coincident scl edge wins as a bit edge
    assign start_cond = ~sda_s & sda_prev_q & scl_s & scl_prev_q;
    assign stop_cond  = sda_s & ~sda_prev_q & scl_s & scl_prev_q;

`ifdef I2C_SLAVE_GENCALL_EN
    assign gencall = (shift_q[ADDR_LEN-1:0] == '0) && !sda_s;
`else
    assign gencall = 1'b0;
`endif
    assign addr_ok = (shift_q[ADDR_LEN-1:0] == SLAVE_ADDR) || gencall;

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda};
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        sda_oe_d   = sda_oe_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        addr_hit_d = addr_hit_q;
        rw_dir_d   = rw_dir_q;
        busy_d     = busy_q;

        // Read byte arrives the cycle after the request; present its MSB straight away
        if (tx_req_q && state_q == S_RD_DATA) begin
            shift_d                = '0;
            shift_d[DATA_LEN-1:0]  = tx_data;
            sda_oe_d               = ~tx_data[DATA_LEN-1];
        end

        case (state_q)
            S_ADDR: if (scl_rise) begin
                shift_d = {shift_q[SHIFT_W-2:0], sda_s};
                cnt_d   = cnt_q + CNT_ONE;
                if (cnt_q == ADDR_LAST) begin
                    cnt_d = '0;
                    if (addr_ok) begin
                        state_d  = S_ADDR_ACK;
                        rw_dir_d = sda_s;
                    end else begin
                        state_d  = S_IGNORE;
                    end
                end
            end
            S_ADDR_ACK: if (scl_fall) begin
                if (!sda_oe_q) begin
                    sda_oe_d   = 1'b1;
                    addr_hit_d = 1'b1;
                end else begin
                    sda_oe_d = 1'b0;
                    if (rw_dir_q) begin
                        state_d  = S_RD_DATA;
                        tx_req_d = 1'b1;
                    end else begin
                        state_d  = S_WR_DATA;
                    end
                end
            end
            S_WR_DATA: if (scl_rise) begin
                shift_d = {shift_q[SHIFT_W-2:0], sda_s};
                cnt_d   = cnt_q + CNT_ONE;
                if (cnt_q == DATA_LAST) begin
                    state_d = S_WR_ACK;
                    cnt_d   = CNT_ONE;
                end
            end
            S_WR_ACK: begin
                // cnt marks the freshly completed byte still waiting in shift_q
                if (cnt_q == CNT_ONE) begin
                    rx_data_d  = shift_q[DATA_LEN-1:0];
                    rx_valid_d = 1'b1;
                    cnt_d      = '0;
                end
                if (scl_fall) begin
                    if (!sda_oe_q) begin
                        sda_oe_d = 1'b1;
                    end else begin
                        sda_oe_d = 1'b0;
                        state_d  = S_WR_DATA;
                    end
                end
            end
            S_RD_DATA: begin
                if (scl_rise) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else if (scl_fall) begin
                    if (cnt_q == DATA_DONE) begin
                        sda_oe_d = 1'b0;
                        state_d  = S_RD_ACK;
                        cnt_d    = '0;
                    end else begin
                        shift_d  = shift_q << 1;
                        sda_oe_d = ~shift_q[DATA_LEN-2];
                    end
                end
            end
            S_RD_ACK: begin
                if (scl_rise) begin
                    if (!sda_s) cnt_d = CNT_ONE;
                    else        state_d = S_IGNORE;
                end else if (scl_fall && cnt_q == CNT_ONE) begin
                    cnt_d    = '0;
                    state_d  = S_RD_DATA;
                    tx_req_d = 1'b1;
                end
            end
            default: ;
        endcase

        if (start_cond) begin
            state_d    = S_ADDR;
            cnt_d      = '0;
            busy_d     = 1'b1;
            addr_hit_d = 1'b0;
            sda_oe_d   = 1'b0;
            tx_req_d   = 1'b0;
        end else if (stop_cond) begin
            state_d    = S_IDLE;
            cnt_d      = '0;
            busy_d     = 1'b0;
            addr_hit_d = 1'b0;
            sda_oe_d   = 1'b0;
            tx_req_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            sda_oe_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            addr_hit_q <= 1'b0;
            rw_dir_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            sda_oe_q   <= sda_oe_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            addr_hit_q <= addr_hit_d;
            rw_dir_q   <= rw_dir_d;
            busy_q     <= busy_d;
        end
    end

    assign sda      = sda_oe_q ? 1'b0 : 1'bz;
    assign tx_req   = tx_req_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign addr_hit = addr_hit_q;
    assign rw_dir   = rw_dir_q;
    assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_target.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_i2c_slave_target: bit-banged I2C master with a transaction-level model |
// | of the target. Honours I2C_SLAVE_GENCALL_EN. Revision: 1.0                |
// +--------------------------------------------------------------------------+
module tb_i2c_slave_target;

    localparam int         Q          = 4;
    localparam logic [6:0] SLAVE_ADDR = 7'h2A;
`ifdef I2C_SLAVE_GENCALL_EN
    localparam bit GC = 1'b1;
`else
    localparam bit GC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       m_low = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_req, rx_valid, addr_hit, rw_dir, busy;
    logic [7:0] rx_data;
    wire        sda;

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_slave_target dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl      (scl),
        .sda      (sda),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .addr_hit (addr_hit),
        .rw_dir   (rw_dir),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] rxq[$];
    int         txreq_n = 0;
    int         tgt_low_n = 0;

    always @(negedge clk) begin
        if (rx_valid) rxq.push_back(rx_data);
        if (tx_req) txreq_n++;
        if (sda === 1'b0 && !m_low) tgt_low_n++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic qwait();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        m_low = 1'b0; qwait();
        scl   = 1'b1; qwait();
        m_low = 1'b1; qwait();
        scl   = 1'b0; qwait();
    endtask

    task automatic bus_stop();
        m_low = 1'b1; qwait();
        scl   = 1'b1; qwait();
        m_low = 1'b0; qwait();
    endtask

    task automatic bus_bit(input logic b, output logic s);
        m_low = ~b;   qwait();
        scl   = 1'b1; qwait();
        s     = sda;  qwait();
        scl   = 1'b0; qwait();
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
        bus_bit(1'b1, ack);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            d[i] = s;
        end
        bus_bit(nack, s);
    endtask

    // Whole transaction: START, address, nb bytes (byte i = data[8i+:8]), STOP.
    task automatic run_xfer(input logic [6:0] a, input logic rw, input int nb, input logic [23:0] data);
        logic       ack, hit;
        logic [7:0] d;
        hit = (a == SLAVE_ADDR) || (GC && a == 7'd0 && !rw);
        rxq.delete();
        txreq_n   = 0;
        tgt_low_n = 0;
        tx_data   = data[7:0];
        bus_start();
        check("busy_start", busy, 1);
        send_byte({a, rw}, ack);
        check("addr_ack", ack, !hit);
        check("addr_hit", addr_hit, hit);
        if (hit) check("rw_dir", rw_dir, rw);
        for (int i = 0; i < nb; i++) begin
            if (rw) begin
                if (i + 1 < nb) tx_data = data[8*(i+1) +: 8];
                recv_byte(i + 1 == nb, d);
                check("rd_byte", d, hit ? data[8*i +: 8] : 8'hFF);
            end else begin
                send_byte(data[8*i +: 8], ack);
                check("wr_ack", ack, !hit);
            end
        end
        bus_stop();
        qwait();
        check("busy_stop", busy, 0);
        check("hit_stop", addr_hit, 0);
        check("rx_count", rxq.size(), (hit && !rw) ? nb : 0);
        for (int i = 0; i < rxq.size() && i < nb; i++) check("rx_data", rxq[i], data[8*i +: 8]);
        check("tx_req_count", txreq_n, (hit && rw) ? nb : 0);
        if (!hit) check("tgt_quiet", tgt_low_n, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic       ack, s;
        logic [7:0] d;
        logic [6:0] a;
        int         r;

        repeat (5) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_addr_hit", addr_hit, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_sda", sda, 1);
        rst_n = 1'b1;
        qwait();

        run_xfer(SLAVE_ADDR, 1'b0, 2, 24'h003CA5);
        run_xfer(7'h2B, 1'b0, 1, 24'h000011);
        run_xfer(SLAVE_ADDR, 1'b1, 2, 24'h00C35A);
        run_xfer(7'h00, 1'b0, 1, 24'h000006);
        run_xfer(7'h00, 1'b1, 1, 24'h000055);

        // Write, repeated START, then read back-to-back
        rxq.delete();
        txreq_n = 0;
        bus_start();
        send_byte({SLAVE_ADDR, 1'b0}, ack);
        check("sr_wr_addr_ack", ack, 0);
        check("sr_rw_dir_w", rw_dir, 0);
        send_byte(8'h77, ack);
        check("sr_wr_ack", ack, 0);
        bus_start();
        check("sr_hit_cleared", addr_hit, 0);
        check("sr_rx_count", rxq.size(), 1);
        if (rxq.size() > 0) check("sr_rx_data", rxq[0], 8'h77);
        tx_data = 8'h96;
        send_byte({SLAVE_ADDR, 1'b1}, ack);
        check("sr_rd_addr_ack", ack, 0);
        check("sr_rw_dir_r", rw_dir, 1);
        check("sr_tx_req", txreq_n, 1);
        recv_byte(1'b1, d);
        check("sr_rd_byte", d, 8'h96);
        bus_stop();
        qwait();
        check("sr_busy", busy, 0);

        // Reset in the middle of a read byte while the target holds sda low
        tx_data = 8'hA5;
        bus_start();
        send_byte({SLAVE_ADDR, 1'b1}, ack);
        for (int i = 0; i < 3; i++) bus_bit(1'b1, s);
        m_low = 1'b0; qwait();
        scl   = 1'b1; qwait();
        check("mid_drive_low", sda, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_sda", sda, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_hit", addr_hit, 0);
        check("mid_rst_rw", rw_dir, 0);
        check("mid_rst_txreq", tx_req, 0);
        check("mid_rst_rxv", rx_valid, 0);
        check("mid_rst_rxd", rx_data, 0);
        qwait();
        rst_n = 1'b1;
        qwait();
        run_xfer(SLAVE_ADDR, 1'b0, 2, 24'h00E14B);

        for (int t = 0; t < 12; t++) begin
            r = $urandom_range(0, 9);
            if (r < 5)      a = SLAVE_ADDR;
            else if (r < 7) a = 7'h00;
            else            a = 7'($urandom);
            run_xfer(a, 1'($urandom), $urandom_range(1, 3), 24'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
